// File: rtl/hazard_control_unit_if.sv
// Bundle between the pipeline datapath and the hazard control unit.
//   Pipeline -> HCU : ID/EX operand and destination info, branch resolution, MDU done
//   HCU -> pipeline : stall / flush / bubble controls, MDU start, watchdog flag,
//                     performance counters
// Modports:
//   slave  - the hazard control unit (consumes pipeline info, drives controls)
//   master - the pipeline / environment side
interface hazard_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       if_id_rs1;
  logic [4:0]       if_id_rs2;
  logic             if_id_uses_rs1;
  logic             if_id_uses_rs2;
  logic [4:0]       id_ex_rd;
  logic             id_ex_mem_read;
  logic             id_ex_is_mdu;
  logic             id_ex_valid;
  logic             branch_taken;
  logic             mdu_done;

  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_bubble;
  logic             mdu_start;
  logic             mdu_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport slave (
    input  if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2,
           id_ex_rd, id_ex_mem_read, id_ex_is_mdu, id_ex_valid,
           branch_taken, mdu_done,
    output pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
           ex_mem_bubble, mdu_start, mdu_timeout, stall_cycles, flush_events
  );

  modport master (
    output if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2,
           id_ex_rd, id_ex_mem_read, id_ex_is_mdu, id_ex_valid,
           branch_taken, mdu_done,
    input  pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
           ex_mem_bubble, mdu_start, mdu_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage RISC-V core.
//   - Load-use hazard: one-cycle bubble (hold PC and IF/ID, flush ID/EX).
//   - Taken branch/jump in EX: flush IF/ID and ID/EX, no stall.
//   - MUL/DIV: start/done handshake, front of pipe held until done, with a
//     watchdog that raises a sticky mdu_timeout flag.
//   - Saturating counters of stalled cycles and flush cycles.
// Ports:
//   clk  - core clock
//   rst  - synchronous active-high reset
//   hcu  - hazard_control_unit_if.slave bundle (see interface file)
// All control outputs are combinational from state and inputs, and are forced
// low while rst is asserted.
module hazard_control_unit #(
  parameter int CNT_W   = 32,
  parameter int MDU_TMO = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_control_unit_if.slave hcu
);

  localparam int WD_W = $clog2(MDU_TMO + 1);

  typedef enum logic {
    IDLE,
    MDU_RUN
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WD_W-1:0]  wdog;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic luse;
  logic mdu_go;
  logic wd_expire;

  logic pc_stall_c;
  logic if_id_stall_c;
  logic id_ex_stall_c;
  logic if_id_flush_c;
  logic id_ex_flush_c;
  logic ex_mem_bubble_c;
  logic mdu_start_c;

  // A load whose destination is read by the instruction in ID; x0 never hazards.
  assign luse = hcu.id_ex_valid && hcu.id_ex_mem_read && (hcu.id_ex_rd != 5'd0) &&
                ((hcu.if_id_uses_rs1 && (hcu.if_id_rs1 == hcu.id_ex_rd)) ||
                 (hcu.if_id_uses_rs2 && (hcu.if_id_rs2 == hcu.id_ex_rd)));

  // A branch in EX means the EX instruction is the branch, not an MDU op.
  assign mdu_go = hcu.id_ex_valid && hcu.id_ex_is_mdu && !hcu.branch_taken;

  // Watchdog counts MDU_RUN cycles from 0; the MDU_TMO-th cycle without done expires.
  assign wd_expire = (state == MDU_RUN) && !hcu.mdu_done &&
                     (wdog == WD_W'(MDU_TMO - 1));

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mdu_go) state_next = MDU_RUN;
      MDU_RUN: if (hcu.mdu_done || wd_expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pc_stall_c      = 1'b0;
    if_id_stall_c   = 1'b0;
    id_ex_stall_c   = 1'b0;
    if_id_flush_c   = 1'b0;
    id_ex_flush_c   = 1'b0;
    ex_mem_bubble_c = 1'b0;
    mdu_start_c     = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (hcu.branch_taken) begin
            // Redirect wins over load-use and MDU entry.
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else if (mdu_go) begin
            pc_stall_c      = 1'b1;
            if_id_stall_c   = 1'b1;
            id_ex_stall_c   = 1'b1;
            ex_mem_bubble_c = 1'b1;
            mdu_start_c     = 1'b1;
          end else if (luse) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end
        end
        MDU_RUN: begin
          // On the done cycle the hold drops so the result advances to EX/MEM.
          // branch_taken here is a protocol violation and is ignored.
          if (!hcu.mdu_done) begin
            pc_stall_c      = 1'b1;
            if_id_stall_c   = 1'b1;
            id_ex_stall_c   = 1'b1;
            ex_mem_bubble_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Watchdog, sticky timeout flag and performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == MDU_RUN) wdog <= wdog + WD_W'(1);
      else                  wdog <= '0;

      if (wd_expire) timeout_q <= 1'b1;

      if (pc_stall_c && (stall_cnt != '1))    stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush_c && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hcu.pc_stall      = pc_stall_c;
  assign hcu.if_id_stall   = if_id_stall_c;
  assign hcu.id_ex_stall   = id_ex_stall_c;
  assign hcu.if_id_flush   = if_id_flush_c;
  assign hcu.id_ex_flush   = id_ex_flush_c;
  assign hcu.ex_mem_bubble = ex_mem_bubble_c;
  assign hcu.mdu_start     = mdu_start_c;
  assign hcu.mdu_timeout   = timeout_q;
  assign hcu.stall_cycles  = stall_cnt;
  assign hcu.flush_events  = flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit. Inputs change on the falling edge,
// outputs are sampled 1 ns later, well away from the rising (active) edge.
// ctl packs {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
//            ex_mem_bubble, mdu_start}.
module tb_hazard_control_unit;

  localparam int CNT_W   = 32;
  localparam int MDU_TMO = 8;

  localparam logic [6:0] C_NONE  = 7'b000_0000;
  localparam logic [6:0] C_LUSE  = 7'b110_0100;
  localparam logic [6:0] C_START = 7'b111_0011;
  localparam logic [6:0] C_RUN   = 7'b111_0010;
  localparam logic [6:0] C_FLUSH = 7'b000_1100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  hazard_control_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_control_unit #(.CNT_W(CNT_W), .MDU_TMO(MDU_TMO)) dut (
    .clk (clk),
    .rst (rst),
    .hcu (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] ctl;
  assign ctl = {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.if_id_flush,
                bus.id_ex_flush, bus.ex_mem_bubble, bus.mdu_start};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus: wait for the falling edge, apply, settle 1 ns.
  task automatic cyc(input logic v, input logic ld, input logic mdu, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic br, input logic done);
    @(negedge clk);
    bus.id_ex_valid    = v;
    bus.id_ex_mem_read = ld;
    bus.id_ex_is_mdu   = mdu;
    bus.id_ex_rd       = rd;
    bus.if_id_rs1      = rs1;
    bus.if_id_uses_rs1 = u1;
    bus.if_id_rs2      = rs2;
    bus.if_id_uses_rs2 = u2;
    bus.branch_taken   = br;
    bus.mdu_done       = done;
    #1;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    idle_cyc();
    idle_cyc();
    check("rst_ctl", ctl, C_NONE);
    check("rst_stall_cnt", bus.stall_cycles, 0);
    check("rst_flush_cnt", bus.flush_events, 0);
    check("rst_timeout", bus.mdu_timeout, 0);
    rst = 1'b0;

    // 1. lw x5 in EX, ID reads x5 via rs2
    cyc(1, 1, 0, 5'd5, 5'd3, 1, 5'd5, 1, 0, 0);
    check("luse_rs2_ctl", ctl, C_LUSE);
    idle_cyc();
    check("luse_bubble_ctl", ctl, C_NONE);
    check("luse_stall_cnt", bus.stall_cycles, 1);

    // 2. No-hazard cases
    cyc(1, 1, 0, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0);
    check("luse_x0_ctl", ctl, C_NONE);
    cyc(1, 1, 0, 5'd7, 5'd7, 0, 5'd2, 1, 0, 0);
    check("luse_unused_rs1_ctl", ctl, C_NONE);
    cyc(1, 0, 0, 5'd7, 5'd7, 1, 5'd7, 1, 0, 0);
    check("no_load_ctl", ctl, C_NONE);
    idle_cyc();
    check("no_hazard_stall_cnt", bus.stall_cycles, 1);

    // 3. MDU op, done 5 cycles after start
    cyc(1, 0, 1, 5'd9, 5'd0, 0, 5'd0, 0, 0, 0);
    check("mdu_start_ctl", ctl, C_START);
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 0, 1, 5'd9, 5'd0, 0, 5'd0, 0, 0, 0);
      check($sformatf("mdu_run_ctl_%0d", i), ctl, C_RUN);
    end
    cyc(1, 0, 1, 5'd9, 5'd0, 0, 5'd0, 0, 0, 1);
    check("mdu_done_ctl", ctl, C_NONE);
    idle_cyc();
    check("mdu_after_ctl", ctl, C_NONE);
    check("mdu_stall_cnt", bus.stall_cycles, 6);

    // 4. branch_taken with luse, then branch_taken with an MDU op
    cyc(1, 1, 0, 5'd5, 5'd5, 1, 5'd0, 0, 1, 0);
    check("br_luse_ctl", ctl, C_FLUSH);
    idle_cyc();
    check("br_luse_flush_cnt", bus.flush_events, 1);
    check("br_luse_stall_cnt", bus.stall_cycles, 6);
    cyc(1, 0, 1, 5'd9, 5'd0, 0, 5'd0, 0, 1, 0);
    check("br_mdu_ctl", ctl, C_FLUSH);
    idle_cyc();
    check("br_mdu_no_entry_ctl", ctl, C_NONE);
    check("br_mdu_flush_cnt", bus.flush_events, 2);

    // 5. MDU watchdog: start cycle plus MDU_TMO held cycles, then IDLE
    cyc(1, 0, 1, 5'd9, 5'd0, 0, 5'd0, 0, 0, 0);
    check("tmo_start_ctl", ctl, C_START);
    for (int i = 1; i <= MDU_TMO; i++) begin
      cyc(1, 0, 1, 5'd9, 5'd0, 0, 5'd0, 0, 0, 0);
      check($sformatf("tmo_run_ctl_%0d", i), ctl, C_RUN);
      check($sformatf("tmo_flag_low_%0d", i), bus.mdu_timeout, 0);
    end
    idle_cyc();
    check("tmo_idle_ctl", ctl, C_NONE);
    check("tmo_flag_set", bus.mdu_timeout, 1);
    check("tmo_stall_cnt", bus.stall_cycles, 6 + 1 + MDU_TMO);
    cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1);
    check("done_in_idle_ctl", ctl, C_NONE);
    cyc(1, 1, 0, 5'd4, 5'd4, 1, 5'd0, 0, 0, 0);
    check("luse_after_tmo_ctl", ctl, C_LUSE);
    idle_cyc();
    check("tmo_flag_sticky", bus.mdu_timeout, 1);

    // 6. Reset two cycles into MDU_RUN (branch there is ignored)
    cyc(1, 0, 1, 5'd9, 5'd0, 0, 5'd0, 0, 0, 0);
    check("rst6_start_ctl", ctl, C_START);
    cyc(1, 0, 1, 5'd9, 5'd0, 0, 5'd0, 0, 1, 0);
    check("rst6_branch_ignored_ctl", ctl, C_RUN);
    cyc(1, 0, 1, 5'd9, 5'd0, 0, 5'd0, 0, 0, 0);
    check("rst6_run2_ctl", ctl, C_RUN);
    rst = 1'b1;
    idle_cyc();
    rst = 1'b0;
    idle_cyc();
    check("rst6_ctl", ctl, C_NONE);
    check("rst6_timeout", bus.mdu_timeout, 0);
    check("rst6_stall_cnt", bus.stall_cycles, 0);
    check("rst6_flush_cnt", bus.flush_events, 0);
    cyc(1, 1, 0, 5'd5, 5'd3, 1, 5'd5, 1, 0, 0);
    check("rst6_luse_ctl", ctl, C_LUSE);
    idle_cyc();
    check("rst6_luse_bubble_ctl", ctl, C_NONE);
    check("rst6_luse_stall_cnt", bus.stall_cycles, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
